// File: rtl/seven_seg_pkg.sv
//------------------------------------------------------------------------------
// Module   : seven_seg_pkg
// Purpose  : Shared definitions for the seven-segment scanner: digit display
//            modes, the blank cathode pattern and the 0-F glyph table.
//            Cathode patterns are active-low with bit order .GFEDCBA.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seven_seg_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_DEC = 2'd1,
    MODE_HEX = 2'd2,
    MODE_RAW = 2'd3
  } mode_t;

  localparam logic [7:0] CAT_BLANK = 8'hFF;

  // GLYPH[v] is the cathode pattern for hex digit v (index 15 listed first).
  // Lowercase b and d keep them distinguishable from 8 and 0.
  localparam logic [15:0][7:0] GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

endpackage

`default_nettype wire

// File: rtl/seven_seg_scanner_glyph.sv
//------------------------------------------------------------------------------
// Module   : seg_glyph
// Purpose  : Combinational digit decoder. Maps a (mode, value) pair to an
//            active-low cathode pattern.
// Ports    : mode  - display mode of the digit
//            value - numeric value or raw segment pattern
//            cat   - cathode pattern, .GFEDCBA, active-low
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg_glyph
  import seven_seg_pkg::*;
(
  input  mode_t      mode,
  input  logic [7:0] value,
  output logic [7:0] cat
);

  always_comb begin
    cat = CAT_BLANK;
    case (mode)
      MODE_DEC: if (value < 8'd10)      cat = GLYPH[value[3:0]];
      MODE_HEX: if (value[7:4] == 4'h0) cat = GLYPH[value[3:0]];
      MODE_RAW: cat = value;
      default:  cat = CAT_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
//------------------------------------------------------------------------------
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexed common-anode seven-segment driver with a
//            double-buffered frame, PWM brightness and per-digit blinking.
// Ports    : clk, rst_n (async, active-low)
//            load/data_in/mode_in/blink_in - frame capture into pending buffer
//            brightness                    - live PWM duty, 0 = dark
//            seg_cat (active-low .GFEDCBA), seg_an (active-low one-hot)
//            frame_done - pulse after each full scan
//            pending    - a loaded frame is waiting for the frame boundary
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIV_W        = 16,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [8*N_DIGITS-1:0] data_in,
  input  logic [2*N_DIGITS-1:0] mode_in,
  input  logic [N_DIGITS-1:0]   blink_in,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [7:0]            seg_cat,
  output logic [N_DIGITS-1:0]   seg_an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int BLK_W = $clog2(BLINK_FRAMES);

  logic [DIV_W-1:0]    r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic                r_armed;
  logic [7:0]          r_act_data [N_DIGITS];
  mode_t               r_act_mode [N_DIGITS];
  logic [N_DIGITS-1:0] r_act_blink;
  logic [7:0]          r_pnd_data [N_DIGITS];
  mode_t               r_pnd_mode [N_DIGITS];
  logic [N_DIGITS-1:0] r_pnd_blink;
  logic                r_pending;
  logic [BLK_W-1:0]    r_blk_cnt;
  logic                r_blk_on;
  logic [7:0]          r_seg_cat;
  logic [N_DIGITS-1:0] r_seg_an;
  logic                r_frame_done;

  logic                w_tc;
  logic                w_last;
  logic                w_fb;
  logic                w_load;
  logic [BRIGHT_W-1:0] w_lvl;
  logic                w_pwm;
  logic                w_blink_off;
  logic                w_an_on;
  logic [7:0]          w_glyph;

  assign w_tc   = &r_pre;
  assign w_last = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_fb   = w_tc & w_last;
  // The first edge after reset release never samples load, so a strobe
  // overlapping the release cannot sneak into the buffers.
  assign w_load = load & r_armed;

  // Sub-slot 0 stays dark as a guard band against ghosting between digits.
  assign w_lvl       = r_pre[DIV_W-1 -: BRIGHT_W];
  assign w_pwm       = (w_lvl != '0) && (w_lvl < brightness);
  assign w_blink_off = r_act_blink[r_idx] & ~r_blk_on;
  assign w_an_on     = w_pwm & (r_act_mode[r_idx] != MODE_OFF) & ~w_blink_off;

  seg_glyph u_glyph (
    .mode  (r_act_mode[r_idx]),
    .value (r_act_data[r_idx]),
    .cat   (w_glyph)
  );

  // Scan counters, blink timing and frame buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_armed     <= 1'b0;
      r_pending   <= 1'b0;
      r_blk_cnt   <= '0;
      r_blk_on    <= 1'b1;
      r_act_blink <= '0;
      r_pnd_blink <= '0;
      for (int i = 0; i < N_DIGITS; i++) begin
        r_act_data[i] <= '0;
        r_act_mode[i] <= MODE_OFF;
        r_pnd_data[i] <= '0;
        r_pnd_mode[i] <= MODE_OFF;
      end
    end else begin
      r_armed <= 1'b1;
      r_pre   <= r_pre + 1'b1;
      if (w_tc) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end

      if (w_fb) begin
        if (r_blk_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          r_blk_cnt <= '0;
          r_blk_on  <= ~r_blk_on;
        end else begin
          r_blk_cnt <= r_blk_cnt + 1'b1;
        end
      end

      if (w_load && w_fb) begin
        // A load on the boundary skips the pending stage entirely.
        r_act_blink <= blink_in;
        for (int i = 0; i < N_DIGITS; i++) begin
          r_act_data[i] <= data_in[8*i +: 8];
          r_act_mode[i] <= mode_t'(mode_in[2*i +: 2]);
        end
        r_pending <= 1'b0;
      end else begin
        if (w_fb && r_pending) begin
          r_act_blink <= r_pnd_blink;
          for (int i = 0; i < N_DIGITS; i++) begin
            r_act_data[i] <= r_pnd_data[i];
            r_act_mode[i] <= r_pnd_mode[i];
          end
          r_pending <= 1'b0;
        end
        if (w_load) begin
          r_pnd_blink <= blink_in;
          for (int i = 0; i < N_DIGITS; i++) begin
            r_pnd_data[i] <= data_in[8*i +: 8];
            r_pnd_mode[i] <= mode_t'(mode_in[2*i +: 2]);
          end
          r_pending <= 1'b1;
        end
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_cat    <= CAT_BLANK;
      r_seg_an     <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fb;
      if (w_an_on) begin
        r_seg_cat <= w_glyph;
        r_seg_an  <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx);
      end else begin
        r_seg_cat <= CAT_BLANK;
        r_seg_an  <= '1;
      end
    end
  end

  assign seg_cat    = r_seg_cat;
  assign seg_an     = r_seg_an;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

`default_nettype wire
